rx_module: RTL and testbench
============================

RX_MODULE -- requirements
Module: rx_module

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_pin_in  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port rx_en_sig  input  1  receive enable; gates detection of new start bits only.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte; holds its value between frames.
REQ-007 SHALL have port rx_done_sig  output  1  one-cycle pulse when rx_data has just been updated.
REQ-008 SHALL have port rx_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 SHALL use the frame format 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-011 SHALL pass rx_pin_in through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value rx_s.
REQ-012 SHALL register rx_s once more as rx_q and define fall as rx_q=1 and rx_s=0.
REQ-013 SHALL implement states IDLE, START, DATA and STOP, with a bit counter (0..CLKS_PER_BIT-1) and a data-bit index (0..7).
REQ-014 IDLE: when fall=1 and rx_en_sig=1, SHALL move to START and clear the bit counter; otherwise SHALL stay in IDLE.
REQ-015 START: when the bit counter reaches CLKS_PER_BIT/2-1 (integer division), SHALL sample rx_s; if 0, move to DATA, clear the counter and clear the index; if 1 (glitch), return to IDLE with no output pulse.
REQ-016 DATA: when the bit counter reaches CLKS_PER_BIT-1, SHALL shift rx_s into bit [index] of an internal shift register, clear the counter and increment the index; after index 7 is sampled, SHALL move to STOP.
REQ-017 STOP: when the bit counter reaches CLKS_PER_BIT-1, SHALL sample rx_s and return to IDLE in the same cycle.
REQ-018 If the stop sample is 1, SHALL load rx_data from the shift register and pulse rx_done_sig for exactly one cycle on the following clock edge.
REQ-019 If the stop sample is 0, SHALL pulse rx_frame_err for one cycle, leave rx_data unchanged, and SHALL NOT assert rx_done_sig.
REQ-020 rx_done_sig and rx_frame_err SHALL never be high in the same cycle.
REQ-021 Latency: the done pulse SHALL occur CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the cycle in which fall is detected (+-1 cycle, fixed by the implementation and documented).
REQ-022 Deasserting rx_en_sig mid-frame SHALL NOT abort the frame; it only suppresses the next IDLE->START transition.
REQ-023 A line held low after a frame error (break) SHALL NOT start a new frame until a fresh high-to-low fall occurs.
REQ-024 A fall that occurs during START, DATA or STOP SHALL be ignored; there is no resynchronization mid-frame.
REQ-025 The counter and index SHALL be sized by $clog2 of their ranges, with no wrap beyond the terminal values.

Reset
REQ-026 While rst=1, the block SHALL be in state IDLE with rx_data=8'h00, rx_done_sig=0, rx_frame_err=0, rx_busy=0, counters=0 and synchronizer/rx_q=1.
REQ-027 Asserting rst mid-frame SHALL abort the frame immediately, with no done or error pulse; after release, the block SHALL wait for a new fall.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 0xA5 with rx_en_sig=1 -> rx_data=8'hA5, rx_done_sig high exactly 1 cycle, rx_frame_err=0, rx_busy low afterwards.
REQ-029 Send 0x00 then 0xFF back-to-back with no idle gap -> two done pulses, with rx_data=8'h00 and then 8'hFF.
REQ-030 Send a 4-cycle low glitch on the line -> no pulses, rx_busy returns to 0 within 8 cycles, rx_data unchanged.
REQ-031 Send 0x3C with the stop bit forced to 0 -> rx_frame_err pulses once, rx_done_sig=0, rx_data keeps its prior value, and the continued low line produces no new frame.
REQ-032 Send 0x5A with rx_en_sig=0 -> no activity; send it again with rx_en_sig dropped after the start bit -> rx_data=8'h5A.
REQ-033 Assert rst during data bit 3 of a frame -> all outputs return to their reset values, no pulse; a following 0x81 frame is received correctly.

Source files
------------

// File: rtl/rx_module.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle done/frame-error pulses.
// Done pulse lands CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the cycle in which fall is seen.
module rx_module #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin_in,
  input  logic       rx_en_sig,
  output logic [7:0] rx_data,
  output logic       rx_done_sig,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            sync1_q, rx_s, rx_q;
  logic            fall;

  // Synchronizer and edge-detect flops reset high so a released reset never looks like a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      sync1_q <= rx_pin_in;
      rx_s    <= sync1_q;
      rx_q    <= rx_s;
    end
  end

  assign fall = rx_q & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall && rx_en_sig) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntMid) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            state_d = StIdle;  // start bit did not hold low: treat as glitch
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = StStop;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_done_sig  = done_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_rx_module.sv
// Directed bench for rx_module: a frame-level scoreboard predicts busy/done/error/data every cycle.
module tb_rx_module;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic       rx_busy;

  rx_module #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_pin_in    (rx_pin),
    .rx_en_sig    (rx_en),
    .rx_data      (rx_data),
    .rx_done_sig  (rx_done),
    .rx_frame_err (rx_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // Expected frame: busy over cycles [s, e], then a pulse of kind (0 none, 1 done, 2 error) at e+1.
  typedef struct {
    int         s;
    int         e;
    int         kind;
    logic [7:0] d;
  } frame_t;

  frame_t     fq[$];
  logic [7:0] exp_data = 8'h00;
  int         cyc = 0;
  int         pass_cnt = 0;
  int         check_cnt = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         last_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin
    logic exp_busy, exp_done, exp_err;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    while (fq.size() > 0 && cyc > fq[0].e + 1) void'(fq.pop_front());
    if (fq.size() > 0) begin
      if (cyc >= fq[0].s && cyc <= fq[0].e) exp_busy = 1'b1;
      if (cyc == fq[0].e + 1) begin
        if (fq[0].kind == 1) begin
          exp_done = 1'b1;
          exp_data = fq[0].d;
        end else if (fq[0].kind == 2) begin
          exp_err = 1'b1;
        end
      end
    end
    chk("cycle", {21'd0, rx_busy, rx_done, rx_err, rx_data},
        {21'd0, exp_busy, exp_done, exp_err, exp_data});
    if (rx_done && rx_err) chk("excl", 32'd1, 32'd0);
    if (rx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (rx_err) err_cnt++;
  end

  // Drives one 8N1 frame starting now (posedge+1); predicts outcome from enable and stop bit.
  task automatic send(input logic [7:0] b, input logic stop_bit, input bit drop_en);
    int n;
    n = cyc;
    if (rx_en) fq.push_back('{s: n + 3, e: n + 2 + H + 9 * CPB, kind: stop_bit ? 1 : 2, d: b});
    rx_pin = 1'b0;
    tick(CPB);
    if (drop_en) rx_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(CPB);
    end
    rx_pin = stop_bit;
    tick(CPB);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    rst    = 1'b1;
    rx_pin = 1'b1;
    rx_en  = 1'b1;
    tick(3);
    chk("reset_outputs", {21'd0, rx_busy, rx_done, rx_err, rx_data}, 32'd0);
    rst = 1'b0;
    tick(5);

    // Single frame plus absolute latency pin.
    n = cyc;
    send(8'hA5, 1'b1, 1'b0);
    tick(20);
    chk("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    chk("a5_done_cnt", done_cnt, 1);
    chk("a5_err_cnt", err_cnt, 0);
    chk("a5_latency", last_done_cyc - n, 155);
    chk("a5_busy_after", {31'd0, rx_busy}, 32'd0);

    // Back-to-back frames with no idle gap.
    send(8'h00, 1'b1, 1'b0);
    chk("b2b_first_data", {24'd0, rx_data}, 32'h0000_0000);
    send(8'hFF, 1'b1, 1'b0);
    tick(20);
    chk("b2b_data", {24'd0, rx_data}, 32'h0000_00FF);
    chk("b2b_done_cnt", done_cnt, 3);

    // 4-cycle low glitch.
    n = cyc;
    fq.push_back('{s: n + 3, e: n + 2 + H, kind: 0, d: 8'h00});
    rx_pin = 1'b0;
    tick(4);
    rx_pin = 1'b1;
    tick(8);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd0);
    tick(10);
    chk("glitch_data", {24'd0, rx_data}, 32'h0000_00FF);
    chk("glitch_done_cnt", done_cnt, 3);

    // Stop bit low, line then held low (break).
    send(8'h3C, 1'b0, 1'b0);
    tick(200);
    chk("ferr_err_cnt", err_cnt, 1);
    chk("ferr_done_cnt", done_cnt, 3);
    chk("ferr_data", {24'd0, rx_data}, 32'h0000_00FF);
    chk("ferr_break_busy", {31'd0, rx_busy}, 32'd0);
    rx_pin = 1'b1;
    tick(20);

    // Disabled receive, then enable dropped after the start bit.
    rx_en = 1'b0;
    send(8'h5A, 1'b1, 1'b0);
    tick(20);
    chk("en0_done_cnt", done_cnt, 3);
    chk("en0_data", {24'd0, rx_data}, 32'h0000_00FF);
    rx_en = 1'b1;
    tick(2);
    send(8'h5A, 1'b1, 1'b1);
    tick(20);
    chk("endrop_data", {24'd0, rx_data}, 32'h0000_005A);
    chk("endrop_done_cnt", done_cnt, 4);
    rx_en = 1'b1;

    // Reset in the middle of data bit 3.
    b = 8'hC3;
    n = cyc;
    fq.push_back('{s: n + 3, e: n + 2 + H + 9 * CPB, kind: 1, d: b});
    rx_pin = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_pin = b[i];
      tick(CPB);
    end
    rx_pin = b[3];
    tick(H);
    rst    = 1'b1;
    rx_pin = 1'b1;
    fq.delete();
    exp_data = 8'h00;
    tick(3);
    chk("midreset_outputs", {21'd0, rx_busy, rx_done, rx_err, rx_data}, 32'd0);
    rst = 1'b0;
    tick(20);
    chk("midreset_done_cnt", done_cnt, 4);
    send(8'h81, 1'b1, 1'b0);
    tick(20);
    chk("post_reset_data", {24'd0, rx_data}, 32'h0000_0081);
    chk("post_reset_done_cnt", done_cnt, 5);
    chk("total_err_cnt", err_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
